// File: rtl/bus_select_arbiter.sv
// Registered bus-source arbiter: fixed-priority or round-robin selection with a
// grant lock for multi-cycle transfers and a saturating multi-request counter.
module bus_select_arbiter #(
    parameter int N_SRC     = 24,
    parameter int SEL_W     = 5,
    parameter int IDLE_CODE = 31,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_SRC-1:0] src_out,
    input  logic             rr_mode,
    input  logic             hold,
    output logic [SEL_W-1:0] encode_select,
    output logic             sel_valid,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LOCK  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] grant, grant_nxt;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] fixed_cand, rr_cand, cand;
    logic             any_req, multi_req, keep_lock, grant_issue;

    assign any_req   = |src_out;
    assign multi_req = (src_out & (src_out - N_SRC'(1))) != '0;

    // Descending scan so the lowest asserted index is the last one written.
    always_comb begin
        fixed_cand = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src_out[SEL_W'(i)]) fixed_cand = SEL_W'(i);
        end
    end

    // Search starts just above rr_ptr; k = N_SRC lands back on rr_ptr itself.
    always_comb begin
        int   idx;
        logic found;
        rr_cand = rr_ptr;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (!found && src_out[SEL_W'(idx)]) begin
                rr_cand = SEL_W'(idx);
                found   = 1'b1;
            end
        end
    end

    assign cand        = rr_mode ? rr_cand : fixed_cand;
    assign keep_lock   = (state == LOCK) && hold && src_out[grant];
    assign grant_issue = !keep_lock && any_req;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        if (keep_lock) begin
            state_nxt = LOCK;
        end else if (!any_req) begin
            state_nxt = IDLE;
        end else begin
            grant_nxt = cand;
            // A hold seen in IDLE only opens a grant; locking needs an existing one.
            state_nxt = (state != IDLE && hold) ? LOCK : DRIVE;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state         <= IDLE;
            grant         <= '0;
            rr_ptr        <= SEL_W'(N_SRC - 1);
            encode_select <= SEL_W'(IDLE_CODE);
            sel_valid     <= 1'b0;
            conflict      <= 1'b0;
            conflict_cnt  <= '0;
        end else begin
            state         <= state_nxt;
            grant         <= grant_nxt;
            if (grant_issue) rr_ptr <= cand;
            encode_select <= (state_nxt == IDLE) ? SEL_W'(IDLE_CODE) : grant_nxt;
            sel_valid     <= (state_nxt != IDLE);
            conflict      <= multi_req;
            if (multi_req && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_select_arbiter.sv
// Directed bench for bus_select_arbiter: reset, fixed priority, round-robin,
// lock behaviour, conflict-counter saturation and asynchronous clear.
module tb_bus_select_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic [23:0] src_out;
    logic        rr_mode;
    logic        hold;
    logic [4:0]  encode_select;
    logic        sel_valid;
    logic        conflict;
    logic [7:0]  conflict_cnt;

    int errors = 0;
    int checks = 0;

    bus_select_arbiter #(.N_SRC(24), .SEL_W(5), .IDLE_CODE(31), .CNT_W(8)) dut (
        .clk(clk), .clr(clr), .src_out(src_out), .rr_mode(rr_mode), .hold(hold),
        .encode_select(encode_select), .sel_valid(sel_valid),
        .conflict(conflict), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [23:0] s);
        src_out = s;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        #2 clr = 1'b1;
        #2 clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; src_out = '0; rr_mode = 1'b0; hold = 1'b0;
        #7;
        checks++;
        if (encode_select !== 5'd31 || sel_valid !== 1'b0) begin
            errors++; $display("FAIL reset_in_clr: sel=%0d valid=%b, want 31/0", encode_select, sel_valid);
        end
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(24'h0);
            checks++;
            if (encode_select !== 5'd31 || sel_valid !== 1'b0 || conflict_cnt !== 8'd0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: sel=%0d valid=%b cnt=%0d, want 31/0/0",
                         i, encode_select, sel_valid, conflict_cnt);
            end
        end
    endtask

    task automatic test_fixed();
        rr_mode = 1'b0; hold = 1'b0;
        step((24'h1 << 3) | (24'h1 << 20));
        checks++;
        if (encode_select !== 5'd3 || sel_valid !== 1'b1 || conflict !== 1'b1 || conflict_cnt !== 8'd1) begin
            errors++;
            $display("FAIL fixed_conflict: sel=%0d valid=%b conf=%b cnt=%0d, want 3/1/1/1",
                     encode_select, sel_valid, conflict, conflict_cnt);
        end
        step(24'h1 << 21);
        checks++;
        if (encode_select !== 5'd21 || conflict !== 1'b0 || conflict_cnt !== 8'd1) begin
            errors++;
            $display("FAIL fixed_single: sel=%0d conf=%b cnt=%0d, want 21/0/1", encode_select, conflict, conflict_cnt);
        end
        step(24'hFF_FFFF);
        checks++;
        if (encode_select !== 5'd0 || conflict_cnt !== 8'd2) begin
            errors++; $display("FAIL fixed_all: sel=%0d cnt=%0d, want 0/2", encode_select, conflict_cnt);
        end
        step(24'h0);
        checks++;
        if (encode_select !== 5'd31 || sel_valid !== 1'b0) begin
            errors++; $display("FAIL fixed_to_idle: sel=%0d valid=%b, want 31/0", encode_select, sel_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_rot [4];
        exp_rot[0] = 5'd2; exp_rot[1] = 5'd7; exp_rot[2] = 5'd23; exp_rot[3] = 5'd2;
        pulse_clr();
        rr_mode = 1'b1; hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step((24'h1 << 2) | (24'h1 << 7) | (24'h1 << 23));
            checks++;
            if (encode_select !== exp_rot[i] || sel_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_rotate[%0d]: sel=%0d valid=%b, want %0d/1", i, encode_select, sel_valid, exp_rot[i]);
            end
        end
        step(24'hFF_FFFF);
        checks++;
        if (encode_select !== 5'd3) begin
            errors++; $display("FAIL rr_all: sel=%0d, want 3", encode_select);
        end
        step(24'h1 << 3);
        checks++;
        if (encode_select !== 5'd3) begin
            errors++; $display("FAIL rr_own_bit: sel=%0d, want 3", encode_select);
        end
        rr_mode = 1'b0;
        step((24'h1 << 1) | (24'h1 << 10));
        checks++;
        if (encode_select !== 5'd1) begin
            errors++; $display("FAIL mode_fixed: sel=%0d, want 1", encode_select);
        end
        rr_mode = 1'b1;
        step((24'h1 << 1) | (24'h1 << 10));
        checks++;
        if (encode_select !== 5'd10) begin
            errors++; $display("FAIL mode_rr_resume: sel=%0d, want 10", encode_select);
        end
        rr_mode = 1'b0;
    endtask

    task automatic test_lock();
        pulse_clr();
        rr_mode = 1'b0; hold = 1'b1;
        step(24'h0);
        checks++;
        if (encode_select !== 5'd31 || sel_valid !== 1'b0) begin
            errors++; $display("FAIL hold_idle: sel=%0d valid=%b, want 31/0", encode_select, sel_valid);
        end
        step(24'h1 << 5);
        step(24'h1 << 5);
        checks++;
        if (encode_select !== 5'd5) begin
            errors++; $display("FAIL lock_grant: sel=%0d, want 5", encode_select);
        end
        for (int i = 0; i < 3; i++) begin
            step((24'h1 << 1) | (24'h1 << 5));
            checks++;
            if (encode_select !== 5'd5 || sel_valid !== 1'b1) begin
                errors++; $display("FAIL lock_pinned[%0d]: sel=%0d, want 5", i, encode_select);
            end
        end
        step(24'h1 << 1);
        checks++;
        if (encode_select !== 5'd1) begin
            errors++; $display("FAIL lock_release: sel=%0d, want 1", encode_select);
        end
        step((24'h1 << 0) | (24'h1 << 1));
        checks++;
        if (encode_select !== 5'd1) begin
            errors++; $display("FAIL relock: sel=%0d, want 1", encode_select);
        end
        hold = 1'b0;
        step((24'h1 << 0) | (24'h1 << 1));
        checks++;
        if (encode_select !== 5'd0) begin
            errors++; $display("FAIL unlock: sel=%0d, want 0", encode_select);
        end
        // A hold arriving from IDLE must open DRIVE, so a lower request next cycle still wins.
        pulse_clr();
        hold = 1'b1;
        step(24'h1 << 9);
        step((24'h1 << 3) | (24'h1 << 9));
        checks++;
        if (encode_select !== 5'd3) begin
            errors++; $display("FAIL idle_hold_no_lock: sel=%0d, want 3", encode_select);
        end
        step((24'h1 << 0) | (24'h1 << 3));
        checks++;
        if (encode_select !== 5'd3) begin
            errors++; $display("FAIL lock_on_3: sel=%0d, want 3", encode_select);
        end
        #2 clr = 1'b1;
        #1;
        checks++;
        if (encode_select !== 5'd31 || sel_valid !== 1'b0) begin
            errors++; $display("FAIL clr_mid_lock: sel=%0d valid=%b, want 31/0", encode_select, sel_valid);
        end
        #1 clr = 1'b0;
        step((24'h1 << 0) | (24'h1 << 3));
        checks++;
        if (encode_select !== 5'd0) begin
            errors++; $display("FAIL after_clr_fresh: sel=%0d, want 0", encode_select);
        end
        hold = 1'b0;
    endtask

    task automatic test_saturation();
        int exp_cnt;
        pulse_clr();
        rr_mode = 1'b0; hold = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step(24'h3);
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            checks++;
            if (conflict_cnt !== 8'(exp_cnt) || conflict !== 1'b1 || encode_select !== 5'd0) begin
                errors++;
                $display("FAIL sat[%0d]: cnt=%0d conf=%b sel=%0d, want %0d/1/0",
                         i, conflict_cnt, conflict, encode_select, exp_cnt);
            end
        end
        #2 clr = 1'b1;
        #1;
        checks++;
        if (conflict_cnt !== 8'd0 || encode_select !== 5'd31 || sel_valid !== 1'b0 || conflict !== 1'b0) begin
            errors++;
            $display("FAIL async_clr: cnt=%0d sel=%0d valid=%b conf=%b, want 0/31/0/0",
                     conflict_cnt, encode_select, sel_valid, conflict);
        end
        #1 clr = 1'b0;
        step(24'h1 << 7);
        checks++;
        if (encode_select !== 5'd7 || sel_valid !== 1'b1 || conflict_cnt !== 8'd0) begin
            errors++;
            $display("FAIL post_clr: sel=%0d valid=%b cnt=%0d, want 7/1/0", encode_select, sel_valid, conflict_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_lock();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
